// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmit and receive paths.
//   state_t           - FSM state encoding used by the dump sequencer and byte serialiser
//   UART_DATA_BITS    - data bits per 8N1 frame
//   UART_IDLE_LEVEL   - line level when idle and during the stop bit
//   UART_CLKS_PER_BIT - default bit period in clocks (12 MHz / 115200)
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam logic        UART_IDLE_LEVEL   = 1'b1;
  localparam int unsigned UART_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START_BIT = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    FINISH    = 3'd5
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one byte as an 8N1 frame, LSB first.
//   clk, reset_n - clock, asynchronous active-low reset
//   load         - accept byte_in (honoured only while idle)
//   byte_in      - byte to send
//   ready        - idle, or in the final cycle of the stop bit; a load may be
//                  issued in the cycle after ready is seen
//   tx           - registered serial output, idle high
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] byte_in,
  output logic                      ready,
  output logic                      tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam int unsigned BitW = $clog2(UART_DATA_BITS);
  localparam logic [BitW-1:0] BitMax = BitW'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
  end

  state_t                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [BitW-1:0]           bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      tick;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START_BIT;
          shift_d = byte_in;
          cnt_d   = '0;
        end
      end
      START_BIT: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitMax) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so the pin never sees decode glitches.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      START_BIT: tx_d = ~UART_IDLE_LEVEL;
      DATA:      tx_d = shift_d[0];
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Early ready lets the parent spend exactly one LOAD cycle between frames.
  assign ready = (state_q == IDLE) || ((state_q == STOP) && tick);
  assign tx    = tx_q;

endmodule

// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: on a one-cycle start, sends every register x0..x(NUM_REGS-1)
// over UART as back-to-back 8N1 frames, little-endian within each register.
//   clk, reset_n - clock, asynchronous active-low reset
//   start        - dump request, sampled only while idle
//   rd_addr      - register file read address (always the current register)
//   rd_data      - combinational register file read data
//   tx           - UART serial out, idle high
//   busy         - dump in progress (low again in the done cycle)
//   done         - one-cycle pulse after the final stop bit
module regfile_dump_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int unsigned NumBytes = XLEN / UART_DATA_BITS;
  localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [ByteW-1:0] ByteLast = ByteW'(NumBytes - 1);
  localparam logic [4:0]       RegLast  = 5'(NUM_REGS - 1);

  if ((XLEN % UART_DATA_BITS) != 0 || XLEN == 0) begin : g_bad_xlen
    $error("regfile_dump_tx: XLEN must be a non-zero multiple of 8");
  end
  if (NUM_REGS == 0 || NUM_REGS > 32) begin : g_bad_regs
    $error("regfile_dump_tx: NUM_REGS must be 1..32");
  end

  state_t                    state_q, state_d;
  logic [4:0]                reg_q, reg_d;
  logic [ByteW-1:0]          byte_q, byte_d;
  logic [XLEN-1:0]           word_q, word_d;
  logic [XLEN-1:0]           word_src;
  logic [UART_DATA_BITS-1:0] byte_sel;
  logic                      tx_load;
  logic                      tx_ready;

  // Byte 0 comes straight from the read port in the cycle it is latched;
  // later bytes come from the latched copy so a mid-register write cannot tear it.
  assign word_src = (byte_q == '0) ? rd_data : word_q;
  assign byte_sel = word_src[UART_DATA_BITS*byte_q +: UART_DATA_BITS];

  // Here DATA means "frame in flight in the serialiser".
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    byte_d  = byte_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          reg_d   = '0;
          byte_d  = '0;
        end
      end
      LOAD: begin
        if (byte_q == '0) begin
          word_d = rd_data;
        end
        state_d = DATA;
      end
      DATA: begin
        if (tx_ready) begin
          if (byte_q == ByteLast) begin
            byte_d = '0;
            if (reg_q == RegLast) begin
              reg_d   = '0;
              state_d = FINISH;
            end else begin
              reg_d   = reg_q + 5'd1;
              state_d = LOAD;
            end
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      reg_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
    end
  end

  assign tx_load = (state_q == LOAD);
  assign rd_addr = reg_q;
  assign busy    = (state_q == LOAD) || (state_q == DATA);
  assign done    = (state_q == FINISH);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (tx_load),
    .byte_in(byte_sel),
    .ready  (tx_ready),
    .tx     (tx)
  );

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: a fast instance (4 clocks/bit) for full dumps decoded
// by a UART receiver model, and a 104 clocks/bit instance for exact bit timing.
module tb_regfile_dump_tx;

  localparam int CpbA       = 4;
  localparam int CpbB       = 104;
  localparam int NRegs      = 32;
  localparam int NBytes     = 4 * NRegs;
  localparam int FrameA     = 10 * CpbA + 1;
  localparam int DumpCycles = NBytes * FrameA;
  localparam int NVec       = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fast instance with a full register file model.
  logic        rst_n_a, start_a, tx_a, busy_a, done_a;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [31:0] regs_a [NRegs];
  assign rd_data_a = regs_a[rd_addr_a];

  regfile_dump_tx #(
    .CLKS_PER_BIT(CpbA),
    .NUM_REGS    (NRegs),
    .XLEN        (32)
  ) u_dut_a (
    .clk    (clk),
    .reset_n(rst_n_a),
    .start  (start_a),
    .rd_addr(rd_addr_a),
    .rd_data(rd_data_a),
    .tx     (tx_a),
    .busy   (busy_a),
    .done   (done_a)
  );

  // Slow instance: only x0 matters for single-frame timing.
  logic        rst_n_b, start_b, tx_b, busy_b, done_b;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b, x0_b;
  assign rd_data_b = (rd_addr_b == 5'd0) ? x0_b : 32'h0;

  regfile_dump_tx #(
    .CLKS_PER_BIT(CpbB),
    .NUM_REGS    (NRegs),
    .XLEN        (32)
  ) u_dut_b (
    .clk    (clk),
    .reset_n(rst_n_b),
    .start  (start_b),
    .rd_addr(rd_addr_b),
    .rd_data(rd_data_b),
    .tx     (tx_b),
    .busy   (busy_b),
    .done   (done_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor for the fast instance: done/busy bookkeeping and a mid-bit UART receiver.
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          load_cyc = 0;
  bit          load_seen = 0;
  logic        busy_prev = 1'b0;
  logic [7:0]  rx_q [$];
  bit          rx_active = 0;
  int          rx_cnt = 0;
  logic [7:0]  rx_byte = 8'h0;
  int          framing_err = 0;

  always @(negedge clk) begin
    if (!rst_n_a) begin
      rx_active = 0;
      busy_prev = 1'b0;
    end else begin
      if (done_a === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_a === 1'b1 && busy_prev !== 1'b1 && !load_seen) begin
        load_seen = 1;
        load_cyc  = cyc;
      end
      busy_prev = busy_a;
      if (!rx_active) begin
        if (tx_a === 1'b0) begin
          rx_active = 1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= CpbA + CpbA / 2 && rx_cnt < 9 * CpbA && (rx_cnt % CpbA) == CpbA / 2)
          rx_byte[(rx_cnt - CpbA) / CpbA] = tx_a;
        if (rx_cnt == 9 * CpbA + CpbA / 2) begin
          if (tx_a !== 1'b1) framing_err++;
          rx_q.push_back(rx_byte);
          rx_active = 0;
        end
      end
    end
  end

  // One full dump on the fast instance, checked against a byte stream built from
  // a snapshot of the register file taken at start.
  task automatic do_dump(input string name, input bit poke, input bit tear);
    logic [31:0] snap [NRegs];
    logic [7:0]  exp_q [$];
    int          budget, n, poke_at, bad, first, busy_rise;
    bit          torn;
    for (int r = 0; r < NRegs; r++) snap[r] = regs_a[r];
    for (int r = 0; r < NRegs; r++)
      for (int b = 0; b < 4; b++) exp_q.push_back(snap[r][8*b +: 8]);
    rx_q.delete();
    done_cnt    = 0;
    load_seen   = 0;
    framing_err = 0;
    torn        = 0;
    poke_at     = int'($urandom_range(100, DumpCycles - 100));

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_bit({name, " busy after start"}, busy_a, 1'b1);

    budget = DumpCycles + 100;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      start_a = (poke && n == poke_at) ? 1'b1 : 1'b0;
      if (tear && !torn && rx_q.size() >= 21) begin
        regs_a[5] = 32'h0;
        torn = 1;
      end
      tick();
      n++;
    end
    // Now inside the done cycle: a start here must be ignored.
    start_a = poke ? 1'b1 : 1'b0;
    tick();
    start_a = 1'b0;
    busy_rise = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_a !== 1'b0) busy_rise++;
      tick();
    end

    check_int({name, " done pulses"}, done_cnt, 1);
    check_int({name, " no restart after done"}, busy_rise, 0);
    check_int({name, " frames"}, rx_q.size(), NBytes);
    check_int({name, " done latency"}, done_cyc - load_cyc, DumpCycles);
    check_int({name, " framing errors"}, framing_err, 0);
    bad = 0;
    first = -1;
    for (int i = 0; i < NBytes; i++) begin
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check_int({name, " stream byte errors"}, bad, 0);
    if (first >= 0 && first < rx_q.size())
      $display("  first differing byte %0d: got %h want %h", first, rx_q[first], exp_q[first]);
    check_bit({name, " tx idle"}, tx_a, 1'b1);
    check_int({name, " rd_addr back to 0"}, int'(rd_addr_a), 0);
  endtask

  typedef struct {
    logic [31:0] x0;
    logic [9:0]  levels;  // line level per bit time, start bit first
  } frame_vec_t;

  frame_vec_t vecs [NVec];

  initial begin
    int dev, n;
    logic [31:0] x5_wire;

    vecs[0] = '{x0: 32'h0000_00A5, levels: 10'b1_10100101_0};
    vecs[1] = '{x0: 32'h1234_563C, levels: 10'b1_00111100_0};
    vecs[2] = '{x0: 32'hFFFF_FF80, levels: 10'b1_10000000_0};

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    x0_b    = 32'h0;
    for (int i = 0; i < NRegs; i++) regs_a[i] = 32'h1122_3300 + i;
    tick();
    check_bit("reset tx", tx_a, 1'b1);
    check_bit("reset busy", busy_a, 1'b0);
    check_bit("reset done", done_a, 1'b0);
    check_int("reset rd_addr", int'(rd_addr_a), 0);
    tick();
    rst_n_a = 1'b1;
    dev = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rd_addr_a !== 5'd0) dev++;
      tick();
    end
    check_int("idle hold deviations", dev, 0);

    // Exact single-frame bit timing at 104 clocks per bit.
    for (int i = 0; i < NVec; i++) begin
      rst_n_b = 1'b0;
      tick();
      rst_n_b = 1'b1;
      x0_b = vecs[i].x0;
      tick();
      check_bit($sformatf("vec%0d idle tx", i), tx_b, 1'b1);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check_bit($sformatf("vec%0d busy in N+1", i), busy_b, 1'b1);
      check_bit($sformatf("vec%0d tx high in LOAD", i), tx_b, 1'b1);
      tick();
      for (int seg = 0; seg < 10; seg++) begin
        int bad;
        bad = 0;
        for (int c = 0; c < CpbB; c++) begin
          if (tx_b !== vecs[i].levels[seg]) bad++;
          tick();
        end
        check_int($sformatf("vec%0d bit-time %0d wrong cycles", i, seg), bad, 0);
      end
    end
    rst_n_b = 1'b0;

    // Pattern dump with stray starts mid-dump and in the done cycle.
    do_dump("pattern", 1'b1, 1'b0);
    check_int("pattern byte0", int'(rx_q[0]), 32'h00);
    check_int("pattern byte1", int'(rx_q[1]), 32'h33);
    check_int("pattern byte3", int'(rx_q[3]), 32'h11);
    check_int("pattern byte4", int'(rx_q[4]), 32'h01);
    check_int("pattern byte124", int'(rx_q[124]), 32'h1F);

    for (int i = 0; i < NRegs; i++) regs_a[i] = $urandom;
    do_dump("random", 1'b0, 1'b0);

    for (int i = 0; i < NRegs; i++) regs_a[i] = $urandom;
    regs_a[5] = 32'hDEAD_BEEF;
    do_dump("tear", 1'b0, 1'b1);
    x5_wire = {rx_q[23], rx_q[22], rx_q[21], rx_q[20]};
    check_int("tear x5 on wire", int'(x5_wire), 32'hDEAD_BEEF);

    // Reset during the start bit of x10 byte 2.
    for (int i = 0; i < NRegs; i++) regs_a[i] = $urandom;
    rx_q.delete();
    done_cnt = 0;
    load_seen = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (rx_q.size() < 42 && n < DumpCycles) begin
      tick();
      n++;
    end
    while (tx_a !== 1'b0 && n < DumpCycles) begin
      tick();
      n++;
    end
    check_int("reached x10 byte2 frames", rx_q.size(), 42);
    check_bit("tx low before reset", tx_a, 1'b0);
    rst_n_a = 1'b0;
    #1;
    check_bit("tx high at reset", tx_a, 1'b1);
    check_bit("busy low at reset", busy_a, 1'b0);
    tick();
    tick();
    rst_n_a = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    check_int("no done after reset", done_cnt, 0);
    check_int("no frames after reset", rx_q.size(), 42);
    check_bit("idle after reset", busy_a, 1'b0);
    do_dump("after reset", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
